// File: rtl/iter_shift_ctl_pkg.sv
// Shared types and widths for the iterative shift controller.
// The ITER_SHIFT_STEP4_EN build option does not change anything in this package.
package shift_ctl_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/iter_shift_ctl_if.sv
// Request/result handshake bundle between the execute stage and the shift controller.
// The ITER_SHIFT_STEP4_EN build option does not change this interface.
interface iter_shift_ctl_if;
   import shift_ctl_pkg::*;

   logic              start_valid;
   logic              start_ready;
   logic [DATA_W-1:0] in_data;
   logic [CNT_W-1:0]  in_cnt;
   logic [1:0]        in_op;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport master (
      output start_valid, in_data, in_cnt, in_op, out_ready,
      input  start_ready, out_valid, out_data, busy
   );

   modport slave (
      input  start_valid, in_data, in_cnt, in_op, out_ready,
      output start_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/iter_shift_ctl_shift_step.sv
// Combinational single-step shifter: one bit per call, or four bits when step4 is set.
// step4 is only ever driven high in builds with ITER_SHIFT_STEP4_EN defined.
module shift_step
   import shift_ctl_pkg::*;
(
   input  logic [DATA_W-1:0] work,
   input  op_e               op,
   input  logic              step4,
   output logic [DATA_W-1:0] work_nxt
);

   always_comb begin
      work_nxt = work;
      case (op)
         OP_ROL:  work_nxt = step4 ? {work[11:0], work[15:12]} : {work[14:0], work[15]};
         OP_SLL:  work_nxt = step4 ? {work[11:0], 4'h0}        : {work[14:0], 1'b0};
         OP_ROR:  work_nxt = step4 ? {work[3:0], work[15:4]}   : {work[0], work[15:1]};
         OP_SRL:  work_nxt = step4 ? {4'h0, work[15:4]}        : {1'b0, work[15:1]};
         default: work_nxt = work;
      endcase
   end

endmodule

// File: rtl/iter_shift_ctl.sv
// Iterative 16-bit shift controller: accepts one request, shifts once per clock, holds the result.
// Define ITER_SHIFT_STEP4_EN to take 4-bit steps while at least four shifts remain.
//
//   state | meaning
//   IDLE  | ready for a request, start_ready high
//   SHIFT | stepping the work register, remaining counts down
//   DONE  | result on out_data, waiting for out_ready
module iter_shift_ctl
   import shift_ctl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   iter_shift_ctl_if.slave  bus
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d, work_step;
   logic [CNT_W-1:0]  remaining_q, remaining_d, step_amt;
   op_e               op_q, op_d;
   logic              step4;

`ifdef ITER_SHIFT_STEP4_EN
   assign step4 = (remaining_q >= CNT_W'(4));
`else
   assign step4 = 1'b0;
`endif

   assign step_amt = step4 ? CNT_W'(4) : CNT_W'(1);

   shift_step u_step (
      .work     (work_q),
      .op       (op_q),
      .step4    (step4),
      .work_nxt (work_step)
   );

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      remaining_d = remaining_q;
      op_d        = op_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               work_d      = bus.in_data;
               remaining_d = bus.in_cnt;
               op_d        = op_e'(bus.in_op);
               state_d     = (bus.in_cnt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            work_d      = work_step;
            remaining_d = remaining_q - step_amt;
            if (remaining_q == step_amt) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         remaining_q <= '0;
         op_q        <= OP_ROL;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         remaining_q <= remaining_d;
         op_q        <= op_d;
      end
   end

   // All status outputs decode registered state only; out_data is the work register itself.
   assign bus.start_ready = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.out_data    = work_q;

endmodule

// File: tb/tb_iter_shift_ctl.sv
// Scoreboard bench for iter_shift_ctl: random and directed requests against a shift/latency model.
// Expected latencies follow ITER_SHIFT_STEP4_EN when it is defined for the build.
module tb_iter_shift_ctl;
   import shift_ctl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   iter_shift_ctl_if bus();

   iter_shift_ctl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   rand_ready = 1'b0;
   bit   prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: whole-amount shift/rotate done in one go with 32-bit arithmetic.
   function automatic logic [15:0] ref_shift(input logic [15:0] d, input int cnt, input logic [1:0] op);
      int unsigned x;
      int unsigned r;
      x = 32'(d);
      case (op)
         2'b01:   r = x << cnt;
         2'b11:   r = x >> cnt;
         2'b00:   r = (x << cnt) | (x >> (16 - cnt));
         default: r = (x >> cnt) | (x << (16 - cnt));
      endcase
      return r[15:0];
   endfunction

   function automatic int ref_lat(input int cnt);
`ifdef ITER_SHIFT_STEP4_EN
      return 1 + cnt / 4 + cnt % 4;
`else
      return 1 + cnt;
`endif
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_start_ready"}, 32'(bus.start_ready), 1);
      chk({tag, "_out_valid"},   32'(bus.out_valid), 0);
      chk({tag, "_out_data"},    32'(bus.out_data), 0);
      chk({tag, "_busy"},        32'(bus.busy), 0);
   endtask

   // Called just after a rising edge; returns just after the acceptance edge.
   task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
      bit done;
      done = 1'b0;
      bus.start_valid = 1'b1;
      bus.in_data     = d;
      bus.in_cnt      = c;
      bus.in_op       = op;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (bus.start_ready) done = 1'b1;
      end
      chk("issue_accept", 32'(done), 1);
      @(posedge clk); #1;
      if (done) sb.push_back('{ref_shift(d, int'(c), op), ref_lat(int'(c)), cyc});
      bus.start_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", 32'(sb.size()), 0);
   endtask

   task automatic apply_reset(input int n, input string tag);
      rst = 1'b1;
      sb.delete();
      #1;
      check_reset_values(tag);
      repeat (n) @(posedge clk);
      #1;
      check_reset_values({tag, "_held"});
      rst = 1'b0;
   endtask

   // Monitor: latency on the rising out_valid, data on each handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (bus.out_valid && !prev_valid) begin
               if (sb.size() == 0) chk("unexpected_valid", 32'(sb.size()), 1);
               else chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
               chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
               void'(sb.pop_front());
            end
            prev_valid = bus.out_valid;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      bus.start_valid = 1'b0;
      bus.in_data     = '0;
      bus.in_cnt      = '0;
      bus.in_op       = '0;
      bus.out_ready   = 1'b1;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("por");
      rst = 1'b0;
      @(posedge clk); #1;

      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++)
         issue(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));

      issue(16'($urandom), 4'($urandom_range(8, 15)), 2'($urandom_range(0, 3)));
      @(posedge clk); #1;
      apply_reset(2, "rst_traffic");

      for (int i = 0; i < 20; i++)
         issue(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      wait_drain();

      rand_ready = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      issue(16'h0001, 4'd15, 2'b01);
      issue(16'h8001, 4'd4,  2'b00);
      issue(16'h0001, 4'd1,  2'b10);
      issue(16'hF000, 4'd0,  2'b11);
      wait_drain();

      // Backpressure with a competing request held on the input.
      bus.out_ready = 1'b0;
      issue(16'hF000, 4'd4, 2'b11);
      for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      @(posedge clk); #1;
      bus.start_valid = 1'b1;
      bus.in_data     = 16'h1234;
      bus.in_cnt      = 4'd2;
      bus.in_op       = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data",    32'(bus.out_data), 32'h0F00);
         chk("bp_start_ready", 32'(bus.start_ready), 0);
         chk("bp_busy",        32'(bus.busy), 1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready_after", 32'(bus.start_ready), 1);
      @(posedge clk); #1;
      sb.push_back('{ref_shift(16'h1234, 2, 2'b01), ref_lat(2), cyc});
      bus.start_valid = 1'b0;
      chk("bp_accepted", 32'(bus.busy), 1);
      wait_drain();

      issue(16'h00FF, 4'd10, 2'b01);
      repeat (2) @(posedge clk);
      #1;
      chk("midshift_busy", 32'(bus.busy), 1);
      apply_reset(2, "rst_midshift");
      issue(16'h00FF, 4'd1, 2'b01);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
